// File: rtl/ysyx_22041207_ifu_axi_bridge.sv
// Instruction-fetch AXI4 read bridge: one outstanding single-beat read,
// returned beat right-aligned to the requested byte offset, with slave
// error reporting and an R-channel timeout that drains the late beat.
module ysyx_22041207_ifu_axi_bridge #(
    parameter int unsigned AW          = 64,
    parameter int unsigned DW          = 64,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          rx_r_valid_i,
    output logic          rx_r_ready_o,
    input  logic [AW-1:0] rx_r_addr_i,
    input  logic [7:0]    rx_r_size_i,
    output logic [DW-1:0] rx_data_read_o,
    output logic          rx_data_valid,
    input  logic          rx_data_ready,
    output logic          rx_err,

    output logic          axi_arvalid,
    input  logic          axi_arready,
    output logic [AW-1:0] axi_araddr,
    output logic [2:0]    axi_arsize,
    output logic [7:0]    axi_arlen,
    output logic [1:0]    axi_arburst,

    input  logic          axi_rvalid,
    output logic          axi_rready,
    input  logic [DW-1:0] axi_rdata,
    input  logic [1:0]    axi_rresp,
    input  logic          axi_rlast
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_RESP,
        S_DRAIN
    } state_t;

    localparam int unsigned   CW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    state_t          state_q;
    state_t          state_d;
    logic [AW-1:0]   addr_q;
    logic [2:0]      arsize_q;
    logic [DW-1:0]   data_q;
    logic            err_q;
    logic            timed_out_q;
    logic [CW-1:0]   cnt_q;
    logic            timeout_hit;
    logic [DW-1:0]   rdata_aligned;

    // Single-beat reads only (arlen=0), so rlast carries no information.
    logic            unused_rlast;
    assign unused_rlast = axi_rlast;

    function automatic logic [2:0] mask_to_size(input logic [7:0] mask);
        case (mask)
            8'h01:   return 3'd0;
            8'h03:   return 3'd1;
            8'h0F:   return 3'd2;
            default: return 3'd3;
        endcase
    endfunction

    assign axi_araddr     = addr_q;
    assign axi_arsize     = arsize_q;
    assign axi_arlen      = '0;
    assign axi_arburst    = 2'b01;
    assign rx_data_read_o = data_q;
    assign rx_err         = err_q;

    // Beat alignment and timeout detection feeding the datapath and FSM.
    always_comb begin
        rdata_aligned = axi_rdata >> {addr_q[2:0], 3'b000};
        timeout_hit   = (state_q == S_R) && !axi_rvalid && (cnt_q == CNT_LAST);
    end

    // Next-state logic; handshake outputs decode from the state register only.
    always_comb begin
        state_d       = state_q;
        rx_r_ready_o  = 1'b0;
        axi_arvalid   = 1'b0;
        axi_rready    = 1'b0;
        rx_data_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                rx_r_ready_o = 1'b1;
                if (rx_r_valid_i) state_d = S_AR;
            end
            S_AR: begin
                axi_arvalid = 1'b1;
                if (axi_arready) state_d = S_R;
            end
            S_R: begin
                axi_rready = 1'b1;
                if (axi_rvalid || timeout_hit) state_d = S_RESP;
            end
            S_RESP: begin
                rx_data_valid = 1'b1;
                if (rx_data_ready) state_d = timed_out_q ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: begin
                axi_rready = 1'b1;
                if (axi_rvalid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Request latch, response capture and R-channel timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            arsize_q    <= '0;
            data_q      <= '0;
            err_q       <= 1'b0;
            timed_out_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rx_r_valid_i) begin
                        addr_q      <= rx_r_addr_i;
                        arsize_q    <= mask_to_size(rx_r_size_i);
                        timed_out_q <= 1'b0;
                    end
                end
                S_R: begin
                    if (axi_rvalid) begin
                        cnt_q  <= '0;
                        err_q  <= (axi_rresp != 2'b00);
                        data_q <= (axi_rresp != 2'b00) ? '0 : rdata_aligned;
                    end else if (timeout_hit) begin
                        cnt_q       <= '0;
                        err_q       <= 1'b1;
                        data_q      <= '0;
                        timed_out_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22041207_ifu_axi_bridge.sv
// Self-checking bench for the IF-side AXI read bridge: cycle-exact directed
// scenarios plus randomized fetches against a byte-level reference model.
module tb_ysyx_22041207_ifu_axi_bridge;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_r_valid_i;
    logic          rx_r_ready_o;
    logic [AW-1:0] rx_r_addr_i;
    logic [7:0]    rx_r_size_i;
    logic [DW-1:0] rx_data_read_o;
    logic          rx_data_valid;
    logic          rx_data_ready;
    logic          rx_err;
    logic          axi_arvalid;
    logic          axi_arready;
    logic [AW-1:0] axi_araddr;
    logic [2:0]    axi_arsize;
    logic [7:0]    axi_arlen;
    logic [1:0]    axi_arburst;
    logic          axi_rvalid;
    logic          axi_rready;
    logic [DW-1:0] axi_rdata;
    logic [1:0]    axi_rresp;
    logic          axi_rlast;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    ysyx_22041207_ifu_axi_bridge #(
        .AW(AW),
        .DW(DW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_r_valid_i(rx_r_valid_i),
        .rx_r_ready_o(rx_r_ready_o),
        .rx_r_addr_i(rx_r_addr_i),
        .rx_r_size_i(rx_r_size_i),
        .rx_data_read_o(rx_data_read_o),
        .rx_data_valid(rx_data_valid),
        .rx_data_ready(rx_data_ready),
        .rx_err(rx_err),
        .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready),
        .axi_araddr(axi_araddr),
        .axi_arsize(axi_arsize),
        .axi_arlen(axi_arlen),
        .axi_arburst(axi_arburst),
        .axi_rvalid(axi_rvalid),
        .axi_rready(axi_rready),
        .axi_rdata(axi_rdata),
        .axi_rresp(axi_rresp),
        .axi_rlast(axi_rlast)
    );

    // Advance one cycle; drive and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: AXI size is log2 of the byte count for legal masks, else 8 bytes.
    function automatic logic [2:0] ref_size(input logic [7:0] mask);
        if (mask == 8'h01 || mask == 8'h03 || mask == 8'h0F || mask == 8'hFF)
            return 3'($clog2($countones(mask)));
        return 3'd3;
    endfunction

    // Reference: error beats read as zero, otherwise drop the low addr%8 bytes.
    function automatic logic [63:0] ref_data(input logic [63:0] addr, input logic [63:0] rdata,
                                             input logic [1:0] rresp);
        int unsigned off;
        if (rresp != 2'b00) return 64'd0;
        off = 32'(addr % 64'd8);
        return rdata >> (8 * off);
    endfunction

    // One complete fetch with programmable slave and IF delays, cycle-exact checks.
    task automatic run_fetch(input string tag, input logic [63:0] addr, input logic [7:0] mask,
                             input int unsigned ard, input int unsigned rd,
                             input logic [63:0] rdata, input logic [1:0] rresp,
                             input int unsigned ifd, input bit early_ready);
        logic [2:0]  exp_s;
        logic [63:0] exp_d;
        logic        exp_e;
        exp_s = ref_size(mask);
        exp_d = ref_data(addr, rdata, rresp);
        exp_e = (rresp != 2'b00);

        n_cmp++;
        if (rx_r_ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL %s idle_ready: got %b want 1", tag, rx_r_ready_o);
        end
        rx_r_valid_i = 1'b1;
        rx_r_addr_i  = addr;
        rx_r_size_i  = mask;
        step();
        rx_r_valid_i = 1'b0;
        rx_r_addr_i  = {$urandom, $urandom};
        rx_r_size_i  = 8'($urandom);
        if (early_ready) rx_data_ready = 1'b1;

        for (int i = 0; i <= int'(ard); i++) begin
            axi_arready = (i == int'(ard));
            n_cmp++;
            if (axi_arvalid !== 1'b1 || axi_araddr !== addr || axi_arsize !== exp_s ||
                axi_rready !== 1'b0 || rx_r_ready_o !== 1'b0) begin
                n_bad++;
                $display("FAIL %s ar_phase[%0d]: got arvalid=%b araddr=%h arsize=%0d rready=%b rdy_o=%b want 1 %h %0d 0 0",
                         tag, i, axi_arvalid, axi_araddr, axi_arsize, axi_rready, rx_r_ready_o, addr, exp_s);
            end
            step();
        end
        axi_arready = 1'b0;

        for (int i = 0; i <= int'(rd); i++) begin
            axi_rvalid = (i == int'(rd));
            axi_rdata  = (i == int'(rd)) ? rdata : {$urandom, $urandom};
            axi_rresp  = (i == int'(rd)) ? rresp : 2'($urandom);
            n_cmp++;
            if (axi_rready !== 1'b1 || axi_arvalid !== 1'b0 || rx_data_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL %s r_phase[%0d]: got rready=%b arvalid=%b dvalid=%b want 1 0 0",
                         tag, i, axi_rready, axi_arvalid, rx_data_valid);
            end
            step();
        end
        axi_rvalid    = 1'b0;
        axi_rdata     = {$urandom, $urandom};
        rx_data_ready = 1'b0;

        for (int i = 0; i <= int'(ifd); i++) begin
            rx_data_ready = (i == int'(ifd));
            n_cmp++;
            if (rx_data_valid !== 1'b1 || rx_err !== exp_e || rx_data_read_o !== exp_d ||
                rx_r_ready_o !== 1'b0 || axi_rready !== 1'b0) begin
                n_bad++;
                $display("FAIL %s resp[%0d]: got valid=%b err=%b data=%h rdy_o=%b rready=%b want 1 %b %h 0 0",
                         tag, i, rx_data_valid, rx_err, rx_data_read_o, rx_r_ready_o, axi_rready, exp_e, exp_d);
            end
            step();
        end
        rx_data_ready = 1'b0;

        n_cmp++;
        if (rx_data_valid !== 1'b0 || rx_r_ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL %s after_consume: got valid=%b rdy_o=%b want 0 1", tag, rx_data_valid, rx_r_ready_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        n_cmp++;
        if (rx_r_ready_o !== 1'b1 || axi_arvalid !== 1'b0 || axi_rready !== 1'b0 ||
            rx_data_valid !== 1'b0 || rx_err !== 1'b0 || rx_data_read_o !== 64'd0 ||
            axi_araddr !== 64'd0 || axi_arsize !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_state: got rdy_o=%b arvalid=%b rready=%b dvalid=%b err=%b data=%h araddr=%h arsize=%0d want 1 0 0 0 0 0 0 0",
                     rx_r_ready_o, axi_arvalid, axi_rready, rx_data_valid, rx_err, rx_data_read_o, axi_araddr, axi_arsize);
        end
        n_cmp++;
        if (axi_arlen !== 8'd0 || axi_arburst !== 2'b01) begin
            n_bad++;
            $display("FAIL ar_consts: got arlen=%h arburst=%b want 00 01", axi_arlen, axi_arburst);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_zero_wait();
        run_fetch("zero_wait_off0", 64'h8000_0000, 8'h0F, 0, 0, 64'h1111_2222_0000_0013, 2'b00, 1, 1'b0);
        run_fetch("zero_wait_off4", 64'h8000_0004, 8'h0F, 0, 0, 64'h1111_2222_0000_0013, 2'b00, 1, 1'b0);
    endtask

    task automatic test_slow_slave();
        run_fetch("slow_slave", 64'h8000_0010, 8'hFF, 5, 3, 64'hDEAD_BEEF_CAFE_F00D, 2'b00, 2, 1'b1);
    endtask

    task automatic test_slverr();
        run_fetch("slverr", 64'h8000_0020, 8'h0F, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1, 1'b0);
    endtask

    task automatic test_timeout();
        int unsigned n;
        rx_r_valid_i = 1'b1;
        rx_r_addr_i  = 64'h8000_0030;
        rx_r_size_i  = 8'h0F;
        step();
        rx_r_valid_i = 1'b0;
        axi_arready  = 1'b1;
        step();
        axi_arready  = 1'b0;
        n = 0;
        while (rx_data_valid !== 1'b1 && n < 100) begin
            n++;
            step();
        end
        n_cmp++;
        if (n != TO) begin
            n_bad++;
            $display("FAIL timeout_cycles: got %0d cycles in S_R want %0d", n, TO);
        end
        n_cmp++;
        if (rx_err !== 1'b1 || rx_data_read_o !== 64'd0) begin
            n_bad++;
            $display("FAIL timeout_resp: got err=%b data=%h want 1 0", rx_err, rx_data_read_o);
        end
        step();
        rx_data_ready = 1'b1;
        step();
        rx_data_ready = 1'b0;
        rx_r_valid_i  = 1'b1;
        rx_r_addr_i   = 64'h8000_0040;
        rx_r_size_i   = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (rx_r_ready_o !== 1'b0 || axi_rready !== 1'b1 || rx_data_valid !== 1'b0 || axi_arvalid !== 1'b0) begin
                n_bad++;
                $display("FAIL drain[%0d]: got rdy_o=%b rready=%b dvalid=%b arvalid=%b want 0 1 0 0",
                         i, rx_r_ready_o, axi_rready, rx_data_valid, axi_arvalid);
            end
            step();
        end
        rx_r_valid_i = 1'b0;
        axi_rvalid   = 1'b1;
        axi_rdata    = 64'h5555_AAAA_5555_AAAA;
        axi_rresp    = 2'b00;
        step();
        axi_rvalid   = 1'b0;
        n_cmp++;
        if (rx_r_ready_o !== 1'b1 || rx_data_valid !== 1'b0 || axi_rready !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_exit: got rdy_o=%b dvalid=%b rready=%b want 1 0 0", rx_r_ready_o, rx_data_valid, axi_rready);
        end
        run_fetch("after_timeout", 64'h8000_0008, 8'hFF, 0, 0, 64'h0123_4567_89AB_CDEF, 2'b00, 1, 1'b0);
    endtask

    task automatic test_reset_mid();
        rx_r_valid_i = 1'b1;
        rx_r_addr_i  = 64'h8000_0050;
        rx_r_size_i  = 8'h03;
        step();
        rx_r_valid_i = 1'b0;
        axi_arready  = 1'b1;
        step();
        axi_arready  = 1'b0;
        step();
        rst = 1'b1;
        step();
        n_cmp++;
        if (rx_r_ready_o !== 1'b1 || axi_arvalid !== 1'b0 || axi_rready !== 1'b0 ||
            rx_data_valid !== 1'b0 || rx_err !== 1'b0 || rx_data_read_o !== 64'd0 ||
            axi_araddr !== 64'd0 || axi_arsize !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_mid: got rdy_o=%b arvalid=%b rready=%b dvalid=%b err=%b data=%h araddr=%h arsize=%0d want 1 0 0 0 0 0 0 0",
                     rx_r_ready_o, axi_arvalid, axi_rready, rx_data_valid, rx_err, rx_data_read_o, axi_araddr, axi_arsize);
        end
        rst = 1'b0;
        step();
        run_fetch("after_reset", 64'h8000_0062, 8'h03, 1, 2, 64'h0000_BEEF_0000_0000, 2'b00, 1, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0]  masks [6] = '{8'h01, 8'h03, 8'h0F, 8'hFF, 8'h07, 8'h00};
        logic [63:0] addr;
        logic [1:0]  rresp;
        int unsigned r;
        for (int k = 0; k < 24; k++) begin
            addr  = 64'h8000_0000 + 64'($urandom_range(0, 4095));
            r     = $urandom_range(0, 7);
            rresp = (r < 5) ? 2'b00 : 2'(r);
            run_fetch($sformatf("rand%0d", k), addr, masks[$urandom_range(0, 5)],
                      $urandom_range(0, 4), $urandom_range(0, 6), {$urandom, $urandom}, rresp,
                      $urandom_range(1, 3), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        rst           = 1'b1;
        rx_r_valid_i  = 1'b0;
        rx_r_addr_i   = '0;
        rx_r_size_i   = '0;
        rx_data_ready = 1'b0;
        axi_arready   = 1'b0;
        axi_rvalid    = 1'b0;
        axi_rdata     = '0;
        axi_rresp     = 2'b00;
        axi_rlast     = 1'b1;
        test_reset();
        test_zero_wait();
        test_slow_slave();
        test_slverr();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

endmodule
